uart_tx_sched: RTL and testbench

Round-robin scheduler that shares the single 8N1 UART transmitter among NUM_REQ byte-stream requesters, for example the weight reporter and the debug console. It grants the UART to one requester for a whole packet, which ends with a byte flagged last. It then feeds bytes one at a time using the transmitter's write-strobe and busy handshake. A stalled packet is aborted after a timeout so that other requesters are not starved.

---
 rtl/uart_tx_sched.sv | 204 ++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one 8N1 UART transmitter among NUM_REQ byte-stream requesters.
// Optional statistics outputs (tx_byte_cnt_o, abort_cnt_o) are built when UART_SCHED_STATS_EN is defined.
module uart_tx_sched #(
   parameter int NUM_REQ  = 2,
   parameter int TIMEOUT  = 50000,
   parameter int ACK_WAIT = 3
) (
   input  logic                 sys_clk_i,
   input  logic                 sys_rst_n_i,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   input  logic [8*NUM_REQ-1:0] req_dat_i,
   input  logic [NUM_REQ-1:0]   req_last_i,
   output logic [NUM_REQ-1:0]   req_ready_o,
   output logic [NUM_REQ-1:0]   grant_o,
   output logic                 uart_wr_o,
   output logic [7:0]           uart_dat_o,
   input  logic                 uart_busy_i,
   output logic                 sched_busy_o,
   output logic                 abort_o
`ifdef UART_SCHED_STATS_EN
   ,
   output logic [15:0]          tx_byte_cnt_o,
   output logic [7:0]           abort_cnt_o
`endif
);

   localparam int             IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [15:0]    TO_LAST  = 16'(TIMEOUT - 1);
   localparam logic [3:0]     ACK_LAST = 4'(ACK_WAIT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_ACK,
      ST_DRAIN
   } state_t;

   state_t             state_q, state_d;
   logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]      gidx_q, gidx_d;
   logic [NUM_REQ-1:0] grant_d;
   logic [NUM_REQ-1:0] ready_d;
   logic               wr_d;
   logic [7:0]         dat_d;
   logic               abort_d;
   logic               last_q, last_d;
   logic [15:0]        to_cnt_q, to_cnt_d;
   logic [3:0]         ack_cnt_q, ack_cnt_d;
   logic               hit;
   logic [IW-1:0]      hit_idx;

   // Index arithmetic modulo NUM_REQ, valid for any requester count, not only powers of two.
   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return IW'(sum);
   endfunction

   // Round-robin search: first valid requester at or after rr_ptr_q.
   always_comb begin
      hit     = 1'b0;
      hit_idx = rr_ptr_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!hit && req_valid_i[wrap_add(rr_ptr_q, i)]) begin
            hit     = 1'b1;
            hit_idx = wrap_add(rr_ptr_q, i);
         end
      end
   end

   // NOTE: every signal assigned below gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      gidx_d    = gidx_q;
      grant_d   = grant_o;
      ready_d   = '0;
      wr_d      = 1'b0;
      dat_d     = uart_dat_o;
      abort_d   = 1'b0;
      last_d    = last_q;
      to_cnt_d  = to_cnt_q;
      ack_cnt_d = ack_cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (hit) begin
               gidx_d           = hit_idx;
               grant_d          = '0;
               grant_d[hit_idx] = 1'b1;
               to_cnt_d         = '0;
               state_d          = ST_LOAD;
            end
         end

         ST_LOAD: begin
            if (req_valid_i[gidx_q]) begin
               ready_d[gidx_q] = 1'b1;
               dat_d           = req_dat_i[{gidx_q, 3'b000} +: 8];
               last_d          = req_last_i[gidx_q];
               to_cnt_d        = '0;
               state_d         = ST_SEND;
            end else if (to_cnt_q == TO_LAST) begin
               // Stalled packet: give up so the other requesters are not starved.
               abort_d  = 1'b1;
               grant_d  = '0;
               rr_ptr_d = wrap_add(gidx_q, 1);
               to_cnt_d = '0;
               state_d  = ST_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 16'd1;
            end
         end

         ST_SEND: begin
            if (!uart_busy_i) begin
               wr_d      = 1'b1;
               ack_cnt_d = '0;
               state_d   = ST_ACK;
            end
         end

         ST_ACK: begin
            // Bounded wait: a missed strobe must not lock the scheduler up.
            if (uart_busy_i || ack_cnt_q == ACK_LAST) begin
               ack_cnt_d = '0;
               state_d   = ST_DRAIN;
            end else begin
               ack_cnt_d = ack_cnt_q + 4'd1;
            end
         end

         ST_DRAIN: begin
            if (!uart_busy_i) begin
               if (last_q) begin
                  grant_d  = '0;
                  rr_ptr_d = wrap_add(gidx_q, 1);
                  state_d  = ST_IDLE;
               end else begin
                  state_d  = ST_LOAD;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
      if (!sys_rst_n_i) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= '0;
         gidx_q       <= '0;
         grant_o      <= '0;
         req_ready_o  <= '0;
         uart_wr_o    <= 1'b0;
         uart_dat_o   <= 8'h00;
         abort_o      <= 1'b0;
         sched_busy_o <= 1'b0;
         last_q       <= 1'b0;
         to_cnt_q     <= '0;
         ack_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         gidx_q       <= gidx_d;
         grant_o      <= grant_d;
         req_ready_o  <= ready_d;
         uart_wr_o    <= wr_d;
         uart_dat_o   <= dat_d;
         abort_o      <= abort_d;
         sched_busy_o <= (state_d != ST_IDLE);
         last_q       <= last_d;
         to_cnt_q     <= to_cnt_d;
         ack_cnt_q    <= ack_cnt_d;
      end
   end

`ifdef UART_SCHED_STATS_EN
   // Counters advance with the registered pulses they count and stick at all-ones.
   always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
      if (!sys_rst_n_i) begin
         tx_byte_cnt_o <= '0;
         abort_cnt_o   <= '0;
      end else begin
         if (wr_d && tx_byte_cnt_o != 16'hFFFF) tx_byte_cnt_o <= tx_byte_cnt_o + 16'd1;
         if (abort_d && abort_cnt_o != 8'hFF)   abort_cnt_o   <= abort_cnt_o + 8'd1;
      end
   end
`else
   // Statistics counters are not present in this build.
`endif

   a_grant_onehot: assert property (@(posedge sys_clk_i) disable iff (!sys_rst_n_i)
      $onehot0(grant_o));
   a_wr_single: assert property (@(posedge sys_clk_i) disable iff (!sys_rst_n_i)
      uart_wr_o |=> !uart_wr_o);
   a_busy_grant: assert property (@(posedge sys_clk_i) disable iff (!sys_rst_n_i)
      sched_busy_o == (grant_o != '0));

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: requester drivers, a UART busy model and a scoreboard
// of expected (byte, owner) pairs popped on every write strobe.
module tb_uart_tx_sched;

   localparam int NUM_REQ   = 2;
   localparam int TIMEOUT   = 100;
   localparam int ACK_WAIT  = 3;
   localparam int LONG_BUSY = 4774;
   localparam int BUDGET    = 20000;

   typedef struct {
      logic [7:0] dat;
      logic [1:0] gnt;
   } sb_t;

   logic                 sys_clk_i   = 1'b0;
   logic                 sys_rst_n_i = 1'b1;
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_dat;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ-1:0]   grant;
   logic                 uart_wr;
   logic [7:0]           uart_dat;
   logic                 uart_busy   = 1'b0;
   logic                 sched_busy;
   logic                 abort;

   logic       req_vld_a [NUM_REQ];
   logic [7:0] req_dat_a [NUM_REQ];
   logic       req_lst_a [NUM_REQ];

   int   n_tests = 0;
   int   n_fail  = 0;
   sb_t  sb_q [$];
   int   wr_cyc_q [$];
   int   cyc = 0;
   int   wr_cnt = 0;
   int   abort_cnt = 0;
   int   abort_cyc = 0;
   int   grant_changes = 0;
   logic [1:0] grant_mask = '0;
   logic [1:0] grant_prev = '0;
   int   busy_len = 20;
   int   busy_left = 0;
   bit   start_pending = 0;
   bit   uart_mute = 0;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
      assign req_valid[g]         = req_vld_a[g];
      assign req_dat[8*g +: 8]    = req_dat_a[g];
      assign req_last[g]          = req_lst_a[g];
   end

   uart_tx_sched #(
      .NUM_REQ (NUM_REQ),
      .TIMEOUT (TIMEOUT),
      .ACK_WAIT(ACK_WAIT)
   ) dut (
      .sys_clk_i   (sys_clk_i),
      .sys_rst_n_i (sys_rst_n_i),
      .req_valid_i (req_valid),
      .req_dat_i   (req_dat),
      .req_last_i  (req_last),
      .req_ready_o (req_ready),
      .grant_o     (grant),
      .uart_wr_o   (uart_wr),
      .uart_dat_o  (uart_dat),
      .uart_busy_i (uart_busy),
      .sched_busy_o(sched_busy),
      .abort_o     (abort)
   );

   always #5 sys_clk_i = ~sys_clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // UART model and output monitor: busy rises the cycle after a strobe and lasts busy_len cycles.
   always begin
      @(posedge sys_clk_i);
      #1;
      cyc++;
      if (busy_left != 0) busy_left--;
      if (start_pending) begin
         busy_left     = busy_len;
         start_pending = 0;
      end
      uart_busy = (busy_left != 0);
      if (uart_wr) begin
         wr_cnt++;
         wr_cyc_q.push_back(cyc);
         if (!uart_mute) start_pending = 1;
         check("wr_while_busy", 32'(uart_busy), 32'd0);
         if (sb_q.size() == 0) begin
            check("sb_unexpected_byte", 32'(uart_dat), 32'hFFFF_FFFF);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            check("uart_dat", 32'(uart_dat), 32'(e.dat));
            check("byte_owner", 32'(grant), 32'(e.gnt));
         end
      end
      if (abort) begin
         abort_cnt++;
         abort_cyc = cyc;
      end
      if (grant != grant_prev) grant_changes++;
      grant_prev = grant;
      grant_mask = grant_mask | grant;
   end

   task automatic tick();
      @(posedge sys_clk_i);
      #2;
   endtask

   task automatic clear_mon();
      wr_cnt        = 0;
      abort_cnt     = 0;
      grant_changes = 0;
      grant_mask    = '0;
      wr_cyc_q.delete();
   endtask

   task automatic push(input logic [7:0] dat, input logic [1:0] gnt);
      sb_t e;
      e.dat = dat;
      e.gnt = gnt;
      sb_q.push_back(e);
   endtask

   // Present len bytes (byte i = bytes[8i+7:8i]) and hold each until the ready pulse.
   task automatic send_pkt(input int n, input logic [31:0] bytes, input int len, input logic last_at_end);
      for (int i = 0; i < len; i++) begin
         int waited = 0;
         req_vld_a[n] = 1'b1;
         req_dat_a[n] = bytes[8*i +: 8];
         req_lst_a[n] = last_at_end && (i == len - 1);
         do begin
            tick();
            waited++;
         end while (!req_ready[n] && waited < BUDGET);
         check($sformatf("ready_req%0d_byte%0d", n, i), 32'(req_ready[n]), 32'd1);
         if (!req_ready[n]) break;
      end
      req_vld_a[n] = 1'b0;
      req_lst_a[n] = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while ((sched_busy || uart_busy || sb_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_idle"}, 32'({sched_busy, uart_busy}), 32'd0);
      check({tag, "_sb_drained"}, sb_q.size(), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_grant"}, 32'(grant), 32'd0);
      check({tag, "_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_wr"}, 32'(uart_wr), 32'd0);
      check({tag, "_dat"}, 32'(uart_dat), 32'd0);
      check({tag, "_abort"}, 32'(abort), 32'd0);
      check({tag, "_sched_busy"}, 32'(sched_busy), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d;
      int waited;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_vld_a[i] = 1'b0;
         req_dat_a[i] = 8'h00;
         req_lst_a[i] = 1'b0;
      end

      // Reset state
      #1 sys_rst_n_i = 1'b0;
      repeat (2) tick();
      check_reset_outputs("rst");
      sys_rst_n_i = 1'b1;
      tick();

      // Latency: req1 valid in IDLE at cycle 0, UART idle
      busy_len = 20;
      clear_mon();
      push(8'h5A, 2'b10);
      req_dat_a[1] = 8'h5A;
      req_lst_a[1] = 1'b1;
      req_vld_a[1] = 1'b1;
      tick();
      check("lat_grant_c1", 32'(grant), 32'h2);
      check("lat_ready_c1", 32'(req_ready), 32'h0);
      tick();
      check("lat_ready_c2", 32'(req_ready), 32'h2);
      check("lat_wr_c2", 32'(uart_wr), 32'd0);
      req_vld_a[1] = 1'b0;
      req_lst_a[1] = 1'b0;
      tick();
      check("lat_wr_c3", 32'(uart_wr), 32'd1);
      wait_idle("lat", 200);

      // Three-byte packet from req0 with a slow transmitter
      busy_len = LONG_BUSY;
      clear_mon();
      push(8'h31, 2'b01);
      push(8'h32, 2'b01);
      push(8'h0A, 2'b01);
      send_pkt(0, 32'h000A_3231, 3, 1'b1);
      wait_idle("t1", 6000);
      check("t1_wr_cnt", wr_cnt, 32'd3);
      check("t1_grant_mask", 32'(grant_mask), 32'h1);
      check("t1_grant_changes", grant_changes, 32'd2);
      check("t1_grant_end", 32'(grant), 32'd0);

      // Simultaneous one-byte packets: pointer now at req1, so req1 goes first
      busy_len = 20;
      clear_mon();
      push(8'h71, 2'b10);
      push(8'h61, 2'b01);
      fork
         send_pkt(0, 32'h61, 1, 1'b1);
         send_pkt(1, 32'h71, 1, 1'b1);
      join
      wait_idle("rr", 500);
      check("rr_wr_cnt", wr_cnt, 32'd2);

      // Reset asserted in DRAIN mid-packet
      busy_len = 200;
      clear_mon();
      push(8'h81, 2'b01);
      send_pkt(0, 32'h81, 1, 1'b0);
      req_dat_a[0] = 8'h82;
      req_vld_a[0] = 1'b1;
      waited = 0;
      while (wr_cnt == 0 && waited < 100) begin
         tick();
         waited++;
      end
      check("mid_first_wr", wr_cnt, 32'd1);
      repeat (10) tick();
      check("mid_busy_pre", 32'(sched_busy), 32'd1);
      check("mid_grant_pre", 32'(grant), 32'h1);
      sys_rst_n_i = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      req_vld_a[0] = 1'b0;
      repeat (3) tick();
      sys_rst_n_i = 1'b1;
      check("mid_sb_drained", sb_q.size(), 32'd0);
      tick();

      // Both requesters after reset, two-byte packets: req0 first, no interleave
      busy_len = 30;
      clear_mon();
      push(8'h41, 2'b01);
      push(8'h42, 2'b01);
      push(8'h51, 2'b10);
      push(8'h52, 2'b10);
      fork
         send_pkt(0, 32'h4241, 2, 1'b1);
         send_pkt(1, 32'h5251, 2, 1'b1);
      join
      wait_idle("t2", 2000);
      check("t2_wr_cnt", wr_cnt, 32'd4);
      check("t2_grant_changes", grant_changes, 32'd4);

      // Stalled packet from req0 aborted; pending req1 then served
      busy_len = 30;
      clear_mon();
      push(8'hA1, 2'b01);
      push(8'hB1, 2'b10);
      fork
         send_pkt(0, 32'hA1, 1, 1'b0);
         send_pkt(1, 32'hB1, 1, 1'b1);
      join
      wait_idle("t4", 1000);
      check("t4_abort_cnt", abort_cnt, 32'd1);
      check("t4_wr_cnt", wr_cnt, 32'd2);
      check("t4_grant_changes", grant_changes, 32'd4);
      d = (wr_cyc_q.size() >= 1) ? (abort_cyc - wr_cyc_q[0]) : 0;
      check($sformatf("t4_abort_delay_%0d", d),
            32'((d >= busy_len + TIMEOUT) && (d <= busy_len + TIMEOUT + 4)), 32'd1);

      // Transmitter that never raises busy: ACK times out, packet still completes
      uart_mute = 1;
      clear_mon();
      push(8'hC1, 2'b01);
      push(8'hC2, 2'b01);
      push(8'hC3, 2'b01);
      send_pkt(0, 32'h00C3_C2C1, 3, 1'b1);
      wait_idle("t5", 200);
      check("t5_wr_cnt", wr_cnt, 32'd3);
      if (wr_cyc_q.size() == 3) begin
         check("t5_gap1", wr_cyc_q[1] - wr_cyc_q[0], 32'(ACK_WAIT + 3));
         check("t5_gap2", wr_cyc_q[2] - wr_cyc_q[1], 32'(ACK_WAIT + 3));
      end else begin
         check("t5_gap_samples", wr_cyc_q.size(), 32'd3);
      end
      uart_mute = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
